// File: rtl/miss_issue_sched_if.sv
// Handshake bundle between the miss-detect stage, the miss scheduler and the refill port.
// The slave modport is the scheduler's view; the master modport is the requester/memory view.
//   alloc_*  : new miss request in, free-entry ready and assigned id out
//   issue_*  : entry presented to the memory port, accepted on vld & rdy
//   resp_*   : memory response id in, error pulse for responses that hit no in-flight entry
//   occ_cnt_o: number of occupied entries
interface miss_issue_sched_if #(
    parameter int unsigned PTR_W  = 3,
    parameter int unsigned ADDR_W = 32
);
    logic              alloc_vld_i;
    logic [ADDR_W-1:0] alloc_addr_i;
    logic              alloc_rdy_o;
    logic [PTR_W-1:0]  alloc_id_o;
    logic              issue_vld_o;
    logic [PTR_W-1:0]  issue_id_o;
    logic [ADDR_W-1:0] issue_addr_o;
    logic              issue_rdy_i;
    logic              resp_vld_i;
    logic [PTR_W-1:0]  resp_id_i;
    logic              resp_err_o;
    logic [PTR_W-1:0]  occ_cnt_o;

    modport slave (
        input  alloc_vld_i,
        input  alloc_addr_i,
        output alloc_rdy_o,
        output alloc_id_o,
        output issue_vld_o,
        output issue_id_o,
        output issue_addr_o,
        input  issue_rdy_i,
        input  resp_vld_i,
        input  resp_id_i,
        output resp_err_o,
        output occ_cnt_o
    );

    modport master (
        output alloc_vld_i,
        output alloc_addr_i,
        input  alloc_rdy_o,
        input  alloc_id_o,
        input  issue_vld_o,
        input  issue_id_o,
        input  issue_addr_o,
        output issue_rdy_i,
        output resp_vld_i,
        output resp_id_i,
        input  resp_err_o,
        input  occ_cnt_o
    );
endinterface

// File: rtl/miss_issue_sched.sv
// Miss-queue scheduler. Holds up to ENTRY_NUM outstanding misses, each FREE -> PEND -> INFL -> FREE.
// Pending entries are issued round-robin starting from a rotating read pointer; an entry presented
// to memory without acceptance is locked so id/addr stay stable until it fires. Responses free
// in-flight entries; a response for any other entry is dropped and flagged on resp_err_o.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : synchronous active-low reset
//   bus    : miss_issue_sched_if slave modport (alloc / issue / resp handshakes, occupancy)
module miss_issue_sched #(
    parameter int unsigned ENTRY_NUM = 5,
    parameter int unsigned PTR_W     = 3,
    parameter int unsigned ADDR_W    = 32
) (
    input logic               clk_i,
    input logic               rst_ni,
    miss_issue_sched_if.slave bus
);

    localparam logic [1:0] StFree = 2'd0;
    localparam logic [1:0] StPend = 2'd1;
    localparam logic [1:0] StInfl = 2'd2;

    logic [1:0]        state_q [ENTRY_NUM];
    logic [1:0]        state_d [ENTRY_NUM];
    logic [ADDR_W-1:0] addr_q  [ENTRY_NUM];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              lock_vld_q, lock_vld_d;
    logic [PTR_W-1:0]  lock_id_q, lock_id_d;
    logic              resp_err_q, resp_err_d;
    logic [PTR_W-1:0]  occ_q, occ_d;

    logic [ENTRY_NUM-1:0]   free_vec, pend_vec;
    logic [2*ENTRY_NUM-1:0] pend_dbl;
    logic [ENTRY_NUM-1:0]   pend_rot;

    logic              any_free;
    logic [PTR_W-1:0]  alloc_id;
    logic              alloc_rdy, alloc_fire;
    logic [PTR_W-1:0]  cand_id;
    logic              issue_vld, issue_fire;
    logic [PTR_W-1:0]  issue_id;
    logic [ADDR_W-1:0] issue_addr;
    logic              resp_hit;

    always_comb begin
        for (int i = 0; i < int'(ENTRY_NUM); i++) begin
            free_vec[i] = (state_q[i] == StFree);
            pend_vec[i] = (state_q[i] == StPend);
        end
    end

    // Lowest-index free entry takes the next allocation.
    always_comb begin
        any_free = 1'b0;
        alloc_id = '0;
        for (int i = int'(ENTRY_NUM) - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                any_free = 1'b1;
                alloc_id = PTR_W'(i);
            end
        end
    end

    assign alloc_rdy  = rst_ni & any_free;
    assign alloc_fire = alloc_rdy & bus.alloc_vld_i;

    // Rotate the pending vector so bit k is entry (rd_ptr + k) mod ENTRY_NUM; the lowest set bit
    // is then the round-robin candidate.
    assign pend_dbl = {pend_vec, pend_vec};
    assign pend_rot = ENTRY_NUM'(pend_dbl >> rd_ptr_q);

    always_comb begin
        logic           found;
        logic [PTR_W:0] sum;
        found   = 1'b0;
        sum     = '0;
        cand_id = '0;
        for (int k = 0; k < int'(ENTRY_NUM); k++) begin
            if (!found && pend_rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, rd_ptr_q} + (PTR_W+1)'(k);
                if (sum >= (PTR_W+1)'(ENTRY_NUM)) begin
                    sum = sum - (PTR_W+1)'(ENTRY_NUM);
                end
                cand_id = sum[PTR_W-1:0];
            end
        end
    end

    assign issue_vld  = rst_ni & (lock_vld_q | (|pend_vec));
    assign issue_id   = lock_vld_q ? lock_id_q : cand_id;
    assign issue_fire = issue_vld & bus.issue_rdy_i;

    always_comb begin
        issue_addr = '0;
        for (int i = 0; i < int'(ENTRY_NUM); i++) begin
            if (issue_id == PTR_W'(i)) begin
                issue_addr = addr_q[i];
            end
        end
    end

    // Ids at or above ENTRY_NUM match no entry and therefore count as errors.
    always_comb begin
        resp_hit = 1'b0;
        for (int i = 0; i < int'(ENTRY_NUM); i++) begin
            if (bus.resp_id_i == PTR_W'(i) && state_q[i] == StInfl) begin
                resp_hit = 1'b1;
            end
        end
    end

    // Alloc, issue and resp can only ever target distinct entries, so the updates never collide.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < int'(ENTRY_NUM); i++) begin
            state_d[i] = state_q[i];
            if (alloc_fire && alloc_id == PTR_W'(i)) begin
                state_d[i] = StPend;
            end
            if (issue_fire && issue_id == PTR_W'(i)) begin
                state_d[i] = StInfl;
            end
            if (bus.resp_vld_i && resp_hit && bus.resp_id_i == PTR_W'(i)) begin
                state_d[i] = StFree;
            end
            if (state_d[i] != StFree) begin
                occ_d = occ_d + PTR_W'(1);
            end
        end
    end

    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        rd_ptr_d   = rd_ptr_q;
        if (issue_vld && !bus.issue_rdy_i) begin
            lock_vld_d = 1'b1;
            lock_id_d  = issue_id;
        end else if (issue_fire) begin
            lock_vld_d = 1'b0;
            rd_ptr_d   = (issue_id == PTR_W'(ENTRY_NUM - 1)) ? '0 : issue_id + PTR_W'(1);
        end
    end

    assign resp_err_d = bus.resp_vld_i & ~resp_hit;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(ENTRY_NUM); i++) begin
                state_q[i] <= StFree;
            end
            rd_ptr_q   <= '0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= '0;
            resp_err_q <= 1'b0;
            occ_q      <= '0;
        end else begin
            for (int i = 0; i < int'(ENTRY_NUM); i++) begin
                state_q[i] <= state_d[i];
            end
            rd_ptr_q   <= rd_ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            resp_err_q <= resp_err_d;
            occ_q      <= occ_d;
        end
    end

    // Payload storage needs no reset; it is only read while its entry is occupied.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(ENTRY_NUM); i++) begin
            if (alloc_fire && alloc_id == PTR_W'(i)) begin
                addr_q[i] <= bus.alloc_addr_i;
            end
        end
    end

    assign bus.alloc_rdy_o  = alloc_rdy;
    assign bus.alloc_id_o   = alloc_id;
    assign bus.issue_vld_o  = issue_vld;
    assign bus.issue_id_o   = issue_id;
    assign bus.issue_addr_o = issue_addr;
    assign bus.resp_err_o   = resp_err_q;
    assign bus.occ_cnt_o    = occ_q;

endmodule

// File: tb/tb_miss_issue_sched.sv
module tb_miss_issue_sched;

    localparam int N  = 5;
    localparam int PW = 3;
    localparam int AW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    miss_issue_sched_if #(.PTR_W(PW), .ADDR_W(AW)) bus ();

    miss_issue_sched #(
        .ENTRY_NUM (N),
        .PTR_W     (PW),
        .ADDR_W    (AW)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: entry states 0=free 1=pending 2=in flight; lock = -1 when none.
    int          m_st   [N];
    logic [31:0] m_addr [N];
    int          m_rd;
    int          m_lock;
    bit          m_err;
    int          m_occ;
    bit          m_valid = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_alloc_id();
        for (int i = 0; i < N; i++) if (m_st[i] == 0) return i;
        return -1;
    endfunction

    function automatic int exp_issue_id();
        if (m_lock >= 0) return m_lock;
        for (int k = 0; k < N; k++) if (m_st[(m_rd + k) % N] == 1) return (m_rd + k) % N;
        return -1;
    endfunction

    task automatic drive(input bit av, input logic [31:0] aa, input bit ir, input bit rv,
                         input int rid, input bit rn);
        rst_n            = rn;
        bus.alloc_vld_i  = av;
        bus.alloc_addr_i = aa;
        bus.issue_rdy_i  = ir;
        bus.resp_vld_i   = rv;
        bus.resp_id_i    = PW'(rid);
        #1;
    endtask

    // Compare all outputs against the model, clock once, advance the model.
    task automatic tick();
        int aid, iid, rid;
        bit ivld, hit;
        aid  = exp_alloc_id();
        iid  = exp_issue_id();
        ivld = rst_n && (iid >= 0);
        chk("alloc_rdy", 64'(bus.alloc_rdy_o), 64'(rst_n && aid >= 0));
        if (rst_n && aid >= 0) chk("alloc_id", 64'(bus.alloc_id_o), 64'(aid));
        chk("issue_vld", 64'(bus.issue_vld_o), 64'(ivld));
        if (ivld) begin
            chk("issue_id", 64'(bus.issue_id_o), 64'(iid));
            chk("issue_addr", 64'(bus.issue_addr_o), 64'(m_addr[iid]));
        end
        if (m_valid) begin
            chk("resp_err", 64'(bus.resp_err_o), 64'(m_err));
            chk("occ_cnt", 64'(bus.occ_cnt_o), 64'(m_occ));
        end
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_st[i] = 0;
            m_rd = 0; m_lock = -1; m_err = 1'b0; m_occ = 0; m_valid = 1'b1;
        end else begin
            rid = int'(bus.resp_id_i);
            hit = bus.resp_vld_i && rid < N && m_st[rid] == 2;
            if (ivld && !bus.issue_rdy_i) m_lock = iid;
            if (ivld && bus.issue_rdy_i) begin
                m_st[iid] = 2; m_lock = -1; m_rd = (iid + 1) % N;
            end
            if (bus.alloc_vld_i && aid >= 0) begin
                m_st[aid] = 1; m_addr[aid] = bus.alloc_addr_i;
            end
            if (hit) m_st[rid] = 0;
            m_err = bus.resp_vld_i && !hit;
            m_occ = 0;
            for (int i = 0; i < N; i++) if (m_st[i] != 0) m_occ++;
        end
        @(negedge clk);
    endtask

    task automatic step(input bit av, input logic [31:0] aa, input bit ir, input bit rv,
                        input int rid, input bit rn);
        drive(av, aa, ir, rv, rid, rn);
        tick();
    endtask

    initial begin
        m_rd = 0; m_lock = -1; m_err = 1'b0; m_occ = 0;
        for (int i = 0; i < N; i++) begin m_st[i] = 0; m_addr[i] = '0; end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("rst_occ", 64'(bus.occ_cnt_o), 64'd0);
        chk("rst_err", 64'(bus.resp_err_o), 64'd0);

        // Back-to-back allocs with memory always ready.
        step(1, 32'h100, 1, 0, 0, 1);
        drive(1, 32'h140, 1, 0, 0, 1);
        chk("t1_issue0", 64'(bus.issue_id_o), 64'd0);
        tick();
        drive(1, 32'h180, 1, 0, 0, 1);
        chk("t1_issue1", 64'(bus.issue_id_o), 64'd1);
        tick();
        drive(0, 0, 1, 0, 0, 1);
        chk("t1_issue2", 64'(bus.issue_id_o), 64'd2);
        chk("t1_addr2", 64'(bus.issue_addr_o), 64'h180);
        tick();
        chk("t1_occ", 64'(bus.occ_cnt_o), 64'd3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, i, 1);

        // Fill all entries with memory stalled.
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) step(1, 32'h200 + 32'(i) * 32'h40, 0, 0, 0, 1);
        drive(1, 32'h999, 0, 0, 0, 1);
        chk("t2_full_rdy", 64'(bus.alloc_rdy_o), 64'd0);
        chk("t2_lock_id", 64'(bus.issue_id_o), 64'd0);
        chk("t2_lock_addr", 64'(bus.issue_addr_o), 64'h200);
        tick();
        chk("t2_occ", 64'(bus.occ_cnt_o), 64'd5);
        for (int i = 0; i < N; i++) step(0, 0, 1, 0, 0, 1);
        for (int i = 0; i < N; i++) step(0, 0, 0, 1, i, 1);

        // Wraparound from rd_ptr=3 with pending {1,4}.
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 32'h300 + 32'(i) * 32'h40, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 1, 2, 1);
        step(1, 32'h400, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1);
        step(1, 32'h440, 0, 1, 1, 1);
        drive(1, 32'h480, 0, 0, 0, 1);
        chk("t3_pres4", 64'(bus.issue_id_o), 64'd4);
        tick();
        drive(0, 0, 1, 0, 0, 1);
        chk("t3_first", 64'(bus.issue_id_o), 64'd4);
        tick();
        drive(0, 0, 1, 0, 0, 1);
        chk("t3_second", 64'(bus.issue_id_o), 64'd1);
        chk("t3_addr", 64'(bus.issue_addr_o), 64'h480);
        tick();

        // Lock holds id 3 while id 2 becomes pending at rd_ptr=2; error responses meanwhile.
        step(0, 0, 0, 1, 3, 1);
        step(1, 32'h500, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 2, 1);
        chk("t4_pres3", 64'(bus.issue_id_o), 64'd3);
        tick();
        step(1, 32'h540, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 2, 1);
        chk("t4_hold3", 64'(bus.issue_id_o), 64'd3);
        chk("t4_addr", 64'(bus.issue_addr_o), 64'h500);
        tick();
        chk("t5_err_pend", 64'(bus.resp_err_o), 64'd1);
        chk("t5_occ_a", 64'(bus.occ_cnt_o), 64'd5);
        step(0, 0, 0, 1, 6, 1);
        chk("t5_err_range", 64'(bus.resp_err_o), 64'd1);
        chk("t5_occ_b", 64'(bus.occ_cnt_o), 64'd5);
        drive(0, 0, 1, 0, 0, 1);
        chk("t4_fire3", 64'(bus.issue_id_o), 64'd3);
        tick();
        drive(0, 0, 1, 0, 0, 1);
        chk("t4_then2", 64'(bus.issue_id_o), 64'd2);
        tick();

        // Reset with three in-flight entries.
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 1, 1);
        chk("t6_pre_occ", 64'(bus.occ_cnt_o), 64'd3);
        step(0, 0, 0, 0, 0, 0);
        chk("t6_occ", 64'(bus.occ_cnt_o), 64'd0);
        drive(0, 0, 0, 0, 0, 1);
        chk("t6_ivld", 64'(bus.issue_vld_o), 64'd0);
        tick();
        step(0, 0, 0, 1, 3, 1);
        chk("t6_err", 64'(bus.resp_err_o), 64'd1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int rid;
            rid = ($urandom % 4 == 0) ? int'($urandom % 8) : int'($urandom % N);
            step(bit'($urandom % 2), $urandom, ($urandom % 4) != 0, ($urandom % 3) == 0, rid,
                 ($urandom % 200) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
